// File: rtl/ifft8_serial_if.sv
// Streaming handshake bundle for the serial 8-point IFFT: input sample
// channel and output sample channel, each a valid/ready pair.
interface ifft8_serial_if #(
    parameter int DW = 36
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im
    );
endinterface

// File: rtl/ifft8_serial.sv
// Serial 8-point radix-2 DIT inverse FFT with one time-shared butterfly, output scaled by 1/8.
// States: LOAD takes 8 samples into bit-reversed RAM | COMPUTE runs 12 butterflies | UNLOAD streams x[0..7].
module ifft8_serial #(
    parameter int DW      = 36,
    parameter int TW_FRAC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ifft8_serial_if.slave      bus,
    output logic               busy
);
    localparam int IW    = DW + 3;
    localparam int PW    = IW + TW_FRAC + 2;
    localparam int C_INT = $rtoi(0.70710678 * (2.0 ** TW_FRAC) + 0.5);
    localparam logic signed [PW-1:0] C_W = PW'(C_INT);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ld_cnt_q, ld_cnt_d;
    logic [2:0]          ul_cnt_q, ul_cnt_d;
    logic [3:0]          bf_cnt_q, bf_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [DW-1:0]       out_re_q, out_re_d;
    logic [DW-1:0]       out_im_q, out_im_d;

    logic signed [IW-1:0] ram_re_q [8];
    logic signed [IW-1:0] ram_im_q [8];

    logic [1:0]           stage, bf_idx, tw_k;
    logic [2:0]           addr_a, addr_b, ld_addr, ul_next;
    logic signed [IW-1:0] a_re, a_im, b_re, b_im, t_re, t_im, p_re, p_im;
    logic signed [PW-1:0] prod_re, prod_im;
    logic                 load_we;

    assign stage   = bf_cnt_q[3:2];
    assign bf_idx  = bf_cnt_q[1:0];
    assign ld_addr = {ld_cnt_q[0], ld_cnt_q[1], ld_cnt_q[2]};
    assign ul_next = ul_cnt_q + 3'd1;
    assign load_we = (state_q == S_LOAD) && bus.in_valid && in_ready_q;

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        tw_k   = '0;
        case (stage)
            2'd0: begin
                addr_a = {bf_idx, 1'b0};
                addr_b = {bf_idx, 1'b1};
            end
            2'd1: begin
                addr_a = {bf_idx[1], 1'b0, bf_idx[0]};
                addr_b = {bf_idx[1], 1'b1, bf_idx[0]};
                tw_k   = {bf_idx[0], 1'b0};
            end
            default: begin
                addr_a = {1'b0, bf_idx};
                addr_b = {1'b1, bf_idx};
                tw_k   = bf_idx;
            end
        endcase
    end

    // tw_k indexes W = e^{+j*2*pi*k/8}; only k=1,3 need the constant multiplier
    always_comb begin
        a_re    = ram_re_q[addr_a];
        a_im    = ram_im_q[addr_a];
        b_re    = ram_re_q[addr_b];
        b_im    = ram_im_q[addr_b];
        prod_re = PW'(b_re) * C_W;
        prod_im = PW'(b_im) * C_W;
        p_re    = IW'(prod_re >>> TW_FRAC);
        p_im    = IW'(prod_im >>> TW_FRAC);
        t_re    = b_re;
        t_im    = b_im;
        case (tw_k)
            2'd1: begin
                t_re = p_re - p_im;
                t_im = p_re + p_im;
            end
            2'd2: begin
                t_re = -b_im;
                t_im = b_re;
            end
            2'd3: begin
                t_re = -p_re - p_im;
                t_im = p_re - p_im;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            ram_re_q[ld_addr] <= {{3{bus.in_re[DW-1]}}, bus.in_re};
            ram_im_q[ld_addr] <= {{3{bus.in_im[DW-1]}}, bus.in_im};
        end else if (state_q == S_COMPUTE) begin
            ram_re_q[addr_a] <= a_re + t_re;
            ram_im_q[addr_a] <= a_im + t_im;
            ram_re_q[addr_b] <= a_re - t_re;
            ram_im_q[addr_b] <= a_im - t_im;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        ul_cnt_d    = ul_cnt_q;
        bf_cnt_d    = bf_cnt_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        case (state_q)
            S_LOAD: begin
                if (load_we) begin
                    ld_cnt_d = ld_cnt_q + 3'd1;
                    if (ld_cnt_q == 3'd7) begin
                        state_d  = S_COMPUTE;
                        bf_cnt_d = '0;
                    end
                end
            end
            S_COMPUTE: begin
                bf_cnt_d = bf_cnt_q + 4'd1;
                if (bf_cnt_q == 4'd11) begin
                    state_d  = S_UNLOAD;
                    ul_cnt_d = '0;
                end
            end
            S_UNLOAD: begin
                // first UNLOAD cycle primes the output register with x[0]
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_re_d    = ram_re_q[ul_cnt_q][IW-1:3];
                    out_im_d    = ram_im_q[ul_cnt_q][IW-1:3];
                end else if (bus.out_ready) begin
                    if (ul_cnt_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        ul_cnt_d    = '0;
                        ld_cnt_d    = '0;
                        state_d     = S_LOAD;
                    end else begin
                        ul_cnt_d = ul_next;
                        out_re_d = ram_re_q[ul_next][IW-1:3];
                        out_im_d = ram_im_q[ul_next][IW-1:3];
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            ld_cnt_q    <= '0;
            ul_cnt_q    <= '0;
            bf_cnt_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            ul_cnt_q    <= ul_cnt_d;
            bf_cnt_q    <= bf_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_ifft8_serial.sv
// Directed bench for ifft8_serial: expected samples are queued when a frame is
// driven and checked in order as the block hands them out.
module tb_ifft8_serial;
    localparam int DW = 36;

    typedef longint frame_t [8];
    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } samp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    ifft8_serial_if #(.DW(DW)) bus ();

    ifft8_serial #(.DW(DW), .TW_FRAC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    samp_t sb_q [$];
    int    n_vec = 0;
    int    n_err = 0;
    samp_t mon_e;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic push_exp(input longint re, input longint im);
        samp_t s;
        s.re = DW'(re);
        s.im = DW'(im);
        sb_q.push_back(s);
    endtask

    // Reference 8-point DIT inverse transform, W8^k with k = m*(4>>s)
    task automatic model_push(input frame_t xr, input frame_t xi);
        longint ar [8];
        longint ai [8];
        longint tr, ti, p, q, nar, nai;
        int a, b, k;
        for (int n = 0; n < 8; n++) begin
            ar[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)] = xr[n];
            ai[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)] = xi[n];
        end
        for (int s = 0; s < 3; s++) begin
            for (int g = 0; g < 8; g += (2 << s)) begin
                for (int m = 0; m < (1 << s); m++) begin
                    a = g + m;
                    b = a + (1 << s);
                    k = m * (4 >> s);
                    p = (ar[b] * 46341) >>> 16;
                    q = (ai[b] * 46341) >>> 16;
                    case (k)
                        1:       begin tr = p - q;     ti = p + q;  end
                        2:       begin tr = -ai[b];    ti = ar[b];  end
                        3:       begin tr = -p - q;    ti = p - q;  end
                        default: begin tr = ar[b];     ti = ai[b];  end
                    endcase
                    nar   = ar[a] + tr;
                    nai   = ai[a] + ti;
                    ar[b] = ar[a] - tr;
                    ai[b] = ai[a] - ti;
                    ar[a] = nar;
                    ai[a] = nai;
                end
            end
        end
        for (int n = 0; n < 8; n++) push_exp(ar[n] >>> 3, ai[n] >>> 3);
    endtask

    task automatic send_frame(input frame_t xr, input frame_t xi);
        int w;
        for (int n = 0; n < 8; n++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = DW'(xr[n]);
            bus.in_im    = DW'(xi[n]);
            w = 0;
            @(negedge clk);
            while (!bus.in_ready && w < 60) begin
                @(negedge clk);
                w++;
            end
            chk("in_ready_wait", DW'(bus.in_ready), DW'(1));
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && sb_q.size() > 0; c++) @(posedge clk);
        #1;
        chk("drain", DW'(sb_q.size()), DW'(0));
    endtask

    task automatic check_latency(input string tag);
        int lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk(tag, DW'(lat), DW'(13));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_vec++;
            assert (sb_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_output observed=%0d expected=none", $signed(bus.out_re));
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                n_vec++;
                assert ({bus.out_re, bus.out_im} === mon_e) else begin
                    n_err++;
                    $error("FAIL out_sample observed=(%0d,%0d) expected=(%0d,%0d)",
                           $signed(bus.out_re), $signed(bus.out_im),
                           $signed(mon_e.re), $signed(mon_e.im));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fr, fi;
        samp_t  hold;
        int     lat;
        int     c;

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_in_ready", DW'(bus.in_ready), DW'(0));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_out_re", bus.out_re, '0);
        chk("rst_out_im", bus.out_im, '0);
        chk("rst_busy", DW'(busy), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", DW'(bus.in_ready), DW'(1));
        chk("post_rst_busy", DW'(busy), DW'(0));

        // impulse with latency and in_ready return timing
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin fr[n] = 0; fi[n] = 0; end
        fr[0] = 8000;
        for (int n = 0; n < 8; n++) push_exp(1000, 0);
        send_frame(fr, fi);
        chk("compute_busy", DW'(busy), DW'(1));
        chk("compute_in_ready", DW'(bus.in_ready), DW'(0));
        check_latency("latency_impulse");
        lat = 13;
        while (!bus.in_ready && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("in_ready_return", DW'(lat), DW'(21));
        wait_drain();

        // flat spectrum
        for (int n = 0; n < 8; n++) begin fr[n] = 8; fi[n] = 0; end
        push_exp(8, 0);
        for (int n = 1; n < 8; n++) push_exp(0, 0);
        send_frame(fr, fi);
        wait_drain();

        // single tone at bin 1
        for (int n = 0; n < 8; n++) begin fr[n] = 0; fi[n] = 0; end
        fr[1] = 8000;
        push_exp(1000, 0);   push_exp(707, 707);   push_exp(0, 1000);  push_exp(-707, 707);
        push_exp(-1000, 0);  push_exp(-707, -707); push_exp(0, -1000); push_exp(707, -707);
        send_frame(fr, fi);
        wait_drain();

        // full-scale extremes
        for (int n = 0; n < 8; n++) begin
            fr[n] = (n % 2 == 0) ? -(longint'(1) <<< 35) : (longint'(1) <<< 35) - 1;
            fi[n] = (n < 4) ? (longint'(1) <<< 35) - 1 : -(longint'(1) <<< 35);
        end
        model_push(fr, fi);
        send_frame(fr, fi);
        wait_drain();

        // pseudo-random frames
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) begin
                fr[n] = longint'($signed($urandom)) <<< 3;
                fi[n] = longint'($signed($urandom)) <<< 3;
            end
            model_push(fr, fi);
            send_frame(fr, fi);
            wait_drain();
        end

        // backpressure on x[3], with a stray in_valid during UNLOAD
        bus.out_ready = 1'b0;
        for (int n = 0; n < 8; n++) begin
            fr[n] = longint'($signed($urandom)) <<< 2;
            fi[n] = -(longint'($signed($urandom)) <<< 2);
        end
        model_push(fr, fi);
        send_frame(fr, fi);
        for (int i = 0; i < 8; i++) begin
            c = 0;
            while (!bus.out_valid && c < 40) begin
                @(posedge clk);
                #1;
                c++;
            end
            chk("bp_valid_wait", DW'(bus.out_valid), DW'(1));
            if (i == 3) begin
                hold = sb_q[0];
                bus.in_valid = 1'b1;
                bus.in_re    = DW'(12345);
                bus.in_im    = DW'(-777);
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("bp_hold_re", bus.out_re, hold.re);
                    chk("bp_hold_im", bus.out_im, hold.im);
                    chk("bp_hold_valid", DW'(bus.out_valid), DW'(1));
                    chk("bp_in_ready", DW'(bus.in_ready), DW'(0));
                end
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
        chk("bp_drain", DW'(sb_q.size()), DW'(0));

        // async reset in the middle of COMPUTE, then a clean impulse
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            fr[n] = 5000 + n;
            fi[n] = -300 * n;
        end
        send_frame(fr, fi);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("arst_busy", DW'(busy), DW'(0));
        chk("arst_in_ready", DW'(bus.in_ready), DW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 8; n++) begin fr[n] = 0; fi[n] = 0; end
        fr[0] = 8000;
        for (int n = 0; n < 8; n++) push_exp(1000, 0);
        send_frame(fr, fi);
        check_latency("latency_after_reset");
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", DW'(bus.in_ready), DW'(1));
        chk("idle_busy", DW'(busy), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
